// File: rtl/vx_stream_rr_arbiter.sv
// Round-robin arbiter merging NUM_REQS valid/ready streams into one channel
// through a two-entry registered output stage, with an optional burst quantum.
module vx_stream_rr_arbiter #(
  parameter int NUM_REQS = 4,
  parameter int DATAW    = 32,
  parameter int BURST    = 1,
  parameter int SELW     = $clog2(NUM_REQS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       valid_in,
  input  logic [NUM_REQS*DATAW-1:0] data_in,
  output logic [NUM_REQS-1:0]       ready_in,
  output logic                      valid_out,
  output logic [DATAW-1:0]          data_out,
  output logic [SELW-1:0]           sel_out,
  input  logic                      ready_out
);

  localparam int BCW = $clog2(BURST) + 1;

  // Handshake: a beat moves on a port only in a cycle where valid and ready
  // are both high at the rising edge; ready_in never looks at ready_out.

  logic [SELW-1:0]  r_ptr;
  logic [BCW-1:0]   r_bcnt;
  logic [SELW-1:0]  r_last_g;
  logic [1:0]       r_count;
  logic             r_head;
  logic             r_tail;
  logic [SELW-1:0]  r_sel  [2];
  logic [DATAW-1:0] r_data [2];

  logic                w_found;
  logic [SELW-1:0]     w_g;
  logic [NUM_REQS-1:0] w_g_oh;
  logic                w_others;
  logic                w_space;
  logic                w_acc;
  logic                w_pop;
  logic [DATAW-1:0]    w_g_data;
  logic [BCW-1:0]      w_bcnt_inc;
  logic [SELW-1:0]     w_g_next;
  logic                w_rotate;

  always_comb begin : grant_search
    logic [SELW-1:0] v_cand;
    int              v_idx;
    w_found = 1'b0;
    w_g     = '0;
    v_cand  = '0;
    v_idx   = 0;
    for (int i = 0; i < NUM_REQS; i++) begin
      v_idx = int'(r_ptr) + i;
      if (v_idx >= NUM_REQS) v_idx = v_idx - NUM_REQS;
      v_cand = SELW'(v_idx);
      if (!w_found && valid_in[v_cand]) begin
        w_found = 1'b1;
        w_g     = v_cand;
      end
    end
  end

  assign w_g_oh   = NUM_REQS'(1) << w_g;
  assign w_others = |(valid_in & ~w_g_oh);
  assign w_space  = (r_count != 2'd2);
  // Gating with reset keeps ready_in low while the block is held in reset.
  assign w_acc    = reset && w_found && w_space;
  assign ready_in = w_acc ? w_g_oh : '0;
  assign w_g_data = data_in[int'(w_g)*DATAW +: DATAW];

  assign w_bcnt_inc = (w_g == r_last_g) ? (r_bcnt + BCW'(1)) : BCW'(1);
  assign w_g_next   = (w_g == SELW'(NUM_REQS-1)) ? '0 : (w_g + SELW'(1));
  assign w_rotate   = (w_bcnt_inc == BCW'(BURST)) || !w_others;

  assign valid_out = (r_count != 2'd0);
  assign w_pop     = valid_out && ready_out;
  assign data_out  = r_data[r_head];
  assign sel_out   = r_sel[r_head];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr    <= '0;
      r_bcnt   <= '0;
      r_last_g <= '0;
      r_count  <= 2'd0;
      r_head   <= 1'b0;
      r_tail   <= 1'b0;
      for (int e = 0; e < 2; e++) begin
        r_sel[e]  <= '0;
        r_data[e] <= '0;
      end
    end else begin
      if (w_acc) begin
        r_sel[r_tail]  <= w_g;
        r_data[r_tail] <= w_g_data;
        r_tail         <= ~r_tail;
        r_last_g       <= w_g;
        if (w_rotate) begin
          r_ptr  <= w_g_next;
          r_bcnt <= '0;
        end else begin
          r_ptr  <= w_g;
          r_bcnt <= w_bcnt_inc;
        end
      end
      if (w_pop) r_head <= ~r_head;
      case ({w_acc, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_vx_stream_rr_arbiter.sv
// Bench for vx_stream_rr_arbiter: one BURST=1 and one BURST=3 instance, each
// checked by an expected-beat queue popped whenever the shared channel pops.
module tb_vx_stream_rr_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int SW = 2;
  localparam int EW = SW + W;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   vin  [2];
  logic [N*W-1:0] din  [2];
  logic [N-1:0]   rin  [2];
  logic           vout [2];
  logic [W-1:0]   dout [2];
  logic [SW-1:0]  sout [2];
  logic           rout [2];

  int n_tests = 0;
  int n_fail  = 0;
  int rem   [2][N];
  int beat  [2][N];
  int ebeat [2][N];

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_q_b[$];
  logic [EW-1:0] m_e0, m_e1;

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  vx_stream_rr_arbiter #(.NUM_REQS(N), .DATAW(W), .BURST(1)) dut_b1 (
    .clk(clk), .reset(rst_n), .valid_in(vin[0]), .data_in(din[0]),
    .ready_in(rin[0]), .valid_out(vout[0]), .data_out(dout[0]),
    .sel_out(sout[0]), .ready_out(rout[0])
  );

  vx_stream_rr_arbiter #(.NUM_REQS(N), .DATAW(W), .BURST(3)) dut_b3 (
    .clk(clk), .reset(rst_n), .valid_in(vin[1]), .data_in(din[1]),
    .ready_in(rin[1]), .valid_out(vout[1]), .data_out(dout[1]),
    .sel_out(sout[1]), .ready_out(rout[1])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] beat_data(input int i, input int k);
    return W'((k << 8) | (16 + i));
  endfunction

  function automatic int pending(input int d);
    int s = 0;
    for (int i = 0; i < N; i++) s += rem[d][i];
    return s;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? exp_q.size() : exp_q_b.size();
  endfunction

  // scoreboard
  task automatic push_exp(input int d, input int sel);
    logic [EW-1:0] e;
    e = {SW'(sel), beat_data(sel, ebeat[d][sel])};
    ebeat[d][sel]++;
    if (d == 0) exp_q.push_back(e);
    else        exp_q_b.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && vout[0] && rout[0]) begin
      if (exp_q.size() == 0) check("b1_extra_beat", 64'd1, 64'd0);
      else begin
        m_e0 = exp_q.pop_front();
        check("b1_beat", {sout[0], dout[0]}, m_e0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && vout[1] && rout[1]) begin
      if (exp_q_b.size() == 0) check("b3_extra_beat", 64'd1, 64'd0);
      else begin
        m_e1 = exp_q_b.pop_front();
        check("b3_beat", {sout[1], dout[1]}, m_e1);
      end
    end
  end

  // drivers
  task automatic start_test(input int d);
    for (int i = 0; i < N; i++) begin
      rem[d][i] = 0; beat[d][i] = 0; ebeat[d][i] = 0;
    end
  endtask

  task automatic apply(input int d);
    for (int i = 0; i < N; i++) begin
      vin[d][i] = (rem[d][i] > 0);
      din[d][i*W +: W] = beat_data(i, beat[d][i]);
    end
  endtask

  task automatic step(input int d, output logic [N-1:0] acc);
    apply(d);
    @(negedge clk);
    acc = vin[d] & rin[d];
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc[i]) begin
      rem[d][i]--;
      beat[d][i]++;
    end
    apply(d);
  endtask

  task automatic run(input int d, input int budget, input string tag, output int cycles);
    logic [N-1:0] acc;
    cycles = 0;
    while (pending(d) != 0 && cycles < budget) begin
      step(d, acc);
      cycles++;
    end
    check({tag, "_done"}, pending(d), 0);
  endtask

  task automatic drain(input int d, input string tag);
    int n = 0;
    while (qsize(d) != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check({tag, "_drain"}, qsize(d), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int           cyc;
    int           acc_total;
    logic [N-1:0] acc;
    int           burst_seq [12] = '{1, 1, 1, 2, 2, 2, 1, 1, 1, 2, 2, 2};

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      vin[d] = '0; din[d] = '0; rout[d] = 1'b1;
      start_test(d);
    end

    // reset with every requester valid
    for (int i = 0; i < N; i++) rem[0][i] = 2;
    apply(0);
    vin[1] = 4'hF;
    repeat (3) @(posedge clk);
    #2;
    check("rst_ready_b1", rin[0], 0);
    check("rst_valid_b1", vout[0], 0);
    check("rst_data_b1", dout[0], 0);
    check("rst_sel_b1", sout[0], 0);
    check("rst_ready_b3", rin[1], 0);
    check("rst_valid_b3", vout[1], 0);
    vin[1] = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("first_grant", rin[0], 4'b0001);

    // plain round-robin, one beat per cycle
    for (int k = 0; k < 8; k++) push_exp(0, k % N);
    run(0, 20, "rr", cyc);
    check("rr_cycles", cyc, 8);
    drain(0, "rr");

    // burst quantum of 3 between requesters 1 and 2
    start_test(1);
    rem[1][1] = 6; rem[1][2] = 6;
    for (int k = 0; k < 12; k++) push_exp(1, burst_seq[k]);
    run(1, 30, "burst", cyc);
    check("burst_cycles", cyc, 12);
    drain(1, "burst");

    // single requester streams every cycle
    start_test(1);
    rem[1][1] = 5;
    for (int k = 0; k < 5; k++) push_exp(1, 1);
    run(1, 20, "solo", cyc);
    check("solo_cycles", cyc, 5);
    drain(1, "solo");

    // backpressure: output stalled for 5 cycles
    start_test(0);
    for (int i = 0; i < N; i++) rem[0][i] = 3;
    for (int k = 0; k < 12; k++) push_exp(0, k % N);
    rout[0] = 1'b0;
    acc_total = 0;
    for (int c = 0; c < 5; c++) begin
      step(0, acc);
      acc_total += $countones(acc);
      check("bp_accept_cycle", (acc != 0), (c < 2));
    end
    check("bp_accepts", acc_total, 2);
    check("bp_ready_zero", rin[0], 0);
    check("bp_valid", vout[0], 1);
    rout[0] = 1'b1;
    #1 check("bp_hold", rin[0], 0);
    step(0, acc);
    check("bp_recover", rin[0], 4'b0100);
    run(0, 30, "bp", cyc);
    drain(0, "bp");

    // sparse traffic and pointer wrap
    start_test(0);
    rem[0][2] = 1;
    push_exp(0, 2);
    run(0, 10, "sp_a", cyc);
    rem[0][0] = 1;
    apply(0);
    #1 check("wrap_grant", rin[0], 4'b0001);
    push_exp(0, 0);
    run(0, 10, "sp_b", cyc);
    rem[0][0] = 1; rem[0][2] = 1;
    apply(0);
    #1 check("sparse_grant", rin[0], 4'b0100);
    push_exp(0, 2);
    push_exp(0, 0);
    run(0, 10, "sp_c", cyc);
    drain(0, "sparse");

    // asynchronous reset with both entries full
    start_test(0);
    for (int i = 0; i < N; i++) rem[0][i] = 2;
    rout[0] = 1'b0;
    step(0, acc);
    step(0, acc);
    check("ar_full_valid", vout[0], 1);
    #3 rst_n = 1'b0;
    #1;
    check("ar_valid_drop", vout[0], 0);
    check("ar_ready_drop", rin[0], 0);
    check("ar_data_clear", dout[0], 0);
    exp_q.delete();
    start_test(0);
    apply(0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    rout[0] = 1'b1;
    repeat (3) @(negedge clk);
    check("ar_no_stale", vout[0], 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) rem[0][i] = 1;
    apply(0);
    #1 check("ar_ptr_zero", rin[0], 4'b0001);
    for (int k = 0; k < N; k++) push_exp(0, k);
    run(0, 20, "ar", cyc);
    check("ar_cycles", cyc, 4);
    drain(0, "ar");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vx_stream_rr_arbiter.md
# vx_stream_rr_arbiter

Round-robin arbiter that shares one elastic output channel between NUM_REQS valid/ready requesters. It feeds a two-entry elastic output stage, so backpressure on the shared channel never creates combinational paths from ready_out to any ready_in. Each output beat carries the index of its source requester. A configurable burst quantum lets one requester hold the grant for several beats. Typical use: merging per-warp or per-bank request streams into a single memory or commit port.

## Interface
Parameters:
- NUM_REQS, 4: number of requesters; minimum 2.
- DATAW, 32: payload width per requester.
- BURST, 1: maximum consecutive accepted beats from one requester while another requester is valid; minimum 1.
- SELW, derived: $clog2(NUM_REQS).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; 0 resets all state immediately; deassertion must be synchronous to clk.
- valid_in  in  NUM_REQS  per-requester valid.
- data_in  in  NUM_REQS*DATAW  payloads; requester i occupies bits [i*DATAW +: DATAW].
- ready_in  out  NUM_REQS  per-requester ready; one-hot or zero.
- valid_out  out  1  shared channel valid.
- data_out  out  DATAW  shared channel payload.
- sel_out  out  SELW  index of the requester that produced data_out.
- ready_out  in  1  shared channel ready.

## Operation
- State:
  - ptr (SELW bits): highest-priority requester.
  - bcnt ($clog2(BURST)+1 bits): beats already granted to last_g.
  - last_g (SELW bits): last granted requester.
  - count (0..2): occupancy of the output stage.
  - Two entries, each {sel, data}, plus head/tail pointers.
- space = (count < 2). The output stage never bypasses: a push is not allowed while count==2, even if a pop happens in the same cycle.
- Grant: g is the first requester with valid_in set, searching ptr, ptr+1, … mod NUM_REQS.
- ready_in[g] = space. All other ready_in bits are 0. ready_in is all-zero when no valid_in is set or space==0.
- Accept: valid_in[g] && ready_in[g]. On accept:
  - Push {g, data_in[g]} at the tail.
  - Burst accounting:
    - If g==last_g: bcnt+1; otherwise bcnt=1 and last_g=g.
    - If the new bcnt==BURST, or no other requester has valid_in set: ptr = g+1 mod NUM_REQS and bcnt=0.
    - Otherwise: ptr = g. The same requester keeps priority.
- With BURST=1 this is plain round-robin: ptr always advances past the winner.
- No accept: ptr, bcnt and last_g hold.
- Pop: valid_out && ready_out. The head advances.
- count update: +1 on push only, −1 on pop only, unchanged when both or neither occur.
- valid_out = (count != 0). data_out and sel_out come from the head entry; they are registered storage with no combinational path from any input.
- Requesters must hold valid_in and data_in stable until accepted. The arbiter does not check this.
- Reset (reset==0): count=0, head=tail=0, ptr=0, bcnt=0, last_g=0; both entries cleared to 0.
  - Outputs during reset: valid_out=0, data_out=0, sel_out=0, ready_in=0.
  - Reset mid-transfer discards buffered beats; nothing is replayed.

## Timing
- Latency: a beat accepted at edge T is visible on valid_out/data_out/sel_out after edge T.
- Throughput with ready_out held at 1: one beat per cycle sustained, count toggles 0→1→1….
- ready_out low for k cycles:
  - First accept fills entry 1, second fills entry 2.
  - ready_in goes to 0 the cycle after count reaches 2.
  - ready_in recovers the cycle after the first pop.
- ready_in depends combinationally on valid_in, ptr and count only. There is no path from ready_out to ready_in.
- Pointer wrap: ptr=NUM_REQS-1 that advances goes to 0.
- A single active requester is accepted every cycle regardless of BURST.

## Test plan
- Reset: hold reset=0 with all valid_in=1 → ready_in=0, valid_out=0, data_out=0. After release, first grant goes to requester 0.
- Round-robin, NUM_REQS=4, BURST=1, all valid, ready_out=1, data_in[i]=0x10+i → sel_out sequence 0,1,2,3,0,… on consecutive cycles, one beat per cycle.
- Burst, BURST=3, requesters 1 and 2 always valid → sel_out 1,1,1,2,2,2,1,…. Requester 1 alone → sel_out 1 every cycle.
- Backpressure: ready_out=0 for 5 cycles, all valid → exactly 2 accepts, then ready_in=0. After ready_out=1, beats drain in accept order and arbitration resumes at the correct ptr.
- Sparse/wrap: ptr=3 with only requester 0 valid → requester 0 is granted and ptr becomes 1. Requester 2 then raised → granted next.
- Async reset mid-stream with count=2 → valid_out falls to 0 immediately, without waiting for a clock edge. After release, no stale beat appears and ptr=0.
